// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline hazard sequencer: FSM state codes,
// forwarding select codes, NOP encoding, control bundle type and helpers.
package hazard_ctrl_pkg;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MDU_WAIT = 1'b1;

  // Owned by the forwarding unit; kept here so both blocks share one encoding.
  localparam logic [1:0]  FWD_NONE  = 2'b00;
  localparam logic [1:0]  FWD_MEMWB = 2'b01;
  localparam logic [1:0]  FWD_EXMEM = 2'b10;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_hold;
    logic mdu_busy;
  } haz_ctl_t;

  localparam haz_ctl_t CTL_RESET = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                     id_ex_bubble: 1'b1, ex_hold: 1'b0, mdu_busy: 1'b0};

  function automatic logic load_use_hit(input logic       memread,
                                        input logic [4:0] ex_rd,
                                        input logic [4:0] rs1,
                                        input logic       uses_rs1,
                                        input logic [4:0] rs2,
                                        input logic       uses_rs2);
    return memread && (ex_rd != 5'd0) &&
           ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard sequencer bundle: ID/EX hazard inputs from the pipeline and the
// stage enable / bubble / flush controls returned to it.
interface hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic       id_ex_memread;
  logic [4:0] id_ex_rd;
  logic       ex_branch_taken;
  logic       ex_mdu_start;
  logic       pc_write;
  logic       if_id_write;
  logic       if_id_flush;
  logic       id_ex_bubble;
  logic       ex_hold;
  logic       mdu_busy;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_memread, id_ex_rd,
           ex_branch_taken, ex_mdu_start,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, mdu_busy
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_ex_memread, id_ex_rd,
           ex_branch_taken, ex_mdu_start,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, mdu_busy
  );
endinterface

// File: rtl/hazard_ctrl_mdu_hold_counter.sv
// Down-counter tracking the remaining EX hold cycles of a MUL/DIV op;
// loads on op entry, decrements while holding, flags zero.
module mdu_hold_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stall, taken-branch flush and MUL/DIV EX hold.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cycles,
  output logic [31:0]   flush_count
`endif
);

  // Cycle 0 of the op is spent in RUN, so the counter covers the remaining holds.
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(MDU_LATENCY - 2);

  logic [0:0] state_q, state_d;
  haz_ctl_t   ctl;
  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_zero;
  logic       load_use;

  assign load_use = load_use_hit(hz.id_ex_memread, hz.id_ex_rd,
                                 hz.id_rs1, hz.id_uses_rs1,
                                 hz.id_rs2, hz.id_uses_rs2);

  always_comb begin
    ctl      = '0;
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (hz.ex_branch_taken) begin
          ctl.if_id_flush  = 1'b1;
          ctl.id_ex_bubble = 1'b1;
          ctl.pc_write     = 1'b1;
          ctl.if_id_write  = 1'b1;
        end else if (hz.ex_mdu_start) begin
          ctl.ex_hold = 1'b1;
          cnt_load    = 1'b1;
          state_d     = ST_MDU_WAIT;
        end else if (load_use) begin
          ctl.id_ex_bubble = 1'b1;
        end else begin
          ctl.pc_write    = 1'b1;
          ctl.if_id_write = 1'b1;
        end
      end
      default: begin
        // ex_mdu_start stays high through the final cycle; returning to RUN must not retrigger.
        ctl.mdu_busy = 1'b1;
        if (!cnt_zero) begin
          ctl.ex_hold = 1'b1;
          cnt_dec     = 1'b1;
        end else begin
          ctl.pc_write    = 1'b1;
          ctl.if_id_write = 1'b1;
          state_d         = ST_RUN;
        end
      end
    endcase
    if (!rst_n) begin
      ctl = CTL_RESET;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  mdu_hold_counter #(
    .CNT_W (CNT_W)
  ) u_hold_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (HOLD_INIT),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  assign hz.pc_write     = ctl.pc_write;
  assign hz.if_id_write  = ctl.if_id_write;
  assign hz.if_id_flush  = ctl.if_id_flush;
  assign hz.id_ex_bubble = ctl.id_ex_bubble;
  assign hz.ex_hold      = ctl.ex_hold;
  assign hz.mdu_busy     = ctl.mdu_busy;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!ctl.pc_write)   stall_q <= sat_inc32(stall_q);
      if (ctl.if_id_flush) flush_q <= sat_inc32(flush_q);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule
